// File: rtl/read_bus_pipe.sv
// Registered read-bus selector: picks one of N_SRC sources by enable code behind a
// single valid/ready output register. Optional even parity output under READ_BUS_PARITY_EN.
module read_bus_pipe #(
    parameter int DW    = 32,
    parameter int N_SRC = 6,
    parameter int SELW  = 3,
    parameter int CNTW  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_SRC*DW-1:0]   src_flat,
    input  logic [SELW-1:0]       bus_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DW-1:0]         bus_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sel_err,
`ifdef READ_BUS_PARITY_EN
    output logic                  bus_par,
`endif
    output logic [CNTW-1:0]       xfer_cnt
);

    localparam logic [SELW-1:0] MAX_CODE = SELW'(N_SRC);

    logic [DW-1:0]   dec_data;
    logic            dec_err;

    logic [DW-1:0]   bus_out_q,   bus_out_d;
    logic            out_valid_q, out_valid_d;
    logic            sel_err_q,   sel_err_d;
    logic [CNTW-1:0] xfer_cnt_q,  xfer_cnt_d;
`ifdef READ_BUS_PARITY_EN
    logic            bus_par_q,   bus_par_d;
`endif

    logic accept;
    logic drain;

    // Code c in 1..N_SRC selects source c-1; 0 and out-of-range codes drive zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        dec_data = '0;
        dec_err  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (bus_en == SELW'(k + 1)) begin
                dec_data = src_flat[k*DW +: DW];
            end
        end
        if (bus_en > MAX_CODE) begin
            dec_err = 1'b1;
        end
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    always_comb begin
        bus_out_d   = bus_out_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        xfer_cnt_d  = xfer_cnt_q;
`ifdef READ_BUS_PARITY_EN
        bus_par_d   = bus_par_q;
`endif
        // A load takes priority over a drain so back-to-back transfers leave no bubble.
        if (accept) begin
            bus_out_d   = dec_data;
            sel_err_d   = dec_err;
            out_valid_d = 1'b1;
`ifdef READ_BUS_PARITY_EN
            bus_par_d   = ^dec_data;
`endif
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        if (drain) begin
            xfer_cnt_d = xfer_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            bus_out_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
`ifdef READ_BUS_PARITY_EN
            bus_par_q   <= 1'b0;
`endif
        end else begin
            bus_out_q   <= bus_out_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
`ifdef READ_BUS_PARITY_EN
            bus_par_q   <= bus_par_d;
`endif
        end
    end

    assign bus_out   = bus_out_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = xfer_cnt_q;
`ifdef READ_BUS_PARITY_EN
    assign bus_par   = bus_par_q;
`endif

endmodule

// File: tb/tb_read_bus_pipe.sv
// Scoreboard bench for read_bus_pipe (CNTW=4 so counter wrap is reachable).
module tb_read_bus_pipe;

    localparam int DW    = 32;
    localparam int N_SRC = 6;
    localparam int SELW  = 3;
    localparam int CNTW  = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          par;
    } exp_t;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [DW-1:0]       src [N_SRC];
    logic [N_SRC*DW-1:0] src_flat;
    logic [SELW-1:0]     bus_en = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       bus_out;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                sel_err;
    logic [CNTW-1:0]     xfer_cnt;
`ifdef READ_BUS_PARITY_EN
    logic                bus_par;
`endif

    int checks   = 0;
    int failures = 0;

    exp_t            sb[$];
    logic [CNTW-1:0] exp_cnt = '0;

    always #5 clock = ~clock;

    always_comb begin
        for (int k = 0; k < N_SRC; k++) src_flat[k*DW +: DW] = src[k];
    end

    read_bus_pipe #(.DW(DW), .N_SRC(N_SRC), .SELW(SELW), .CNTW(CNTW)) dut (
        .clock     (clock),
        .reset     (reset),
        .src_flat  (src_flat),
        .bus_en    (bus_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bus_out   (bus_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
`ifdef READ_BUS_PARITY_EN
        .bus_par   (bus_par),
`endif
        .xfer_cnt  (xfer_cnt)
    );

    function automatic exp_t model(input logic [SELW-1:0] code);
        exp_t e;
        e.data = '0;
        e.err  = 1'b0;
        if (code >= 1 && int'(code) <= N_SRC) e.data = src[int'(code) - 1];
        if (int'(code) > N_SRC) e.err = 1'b1;
        e.par = ^e.data;
        return e;
    endfunction

    // Scoreboard monitor: pops on consumption, pushes on acceptance, all from the model's own state.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            automatic logic exp_valid = (sb.size() != 0);
            automatic logic exp_ready = !exp_valid || out_ready;
            checks++;
            if (out_valid !== exp_valid) begin
                failures++;
                $display("FAIL sb_out_valid: got %b expected %b", out_valid, exp_valid);
            end
            checks++;
            if (in_ready !== exp_ready) begin
                failures++;
                $display("FAIL sb_in_ready: got %b expected %b", in_ready, exp_ready);
            end
            checks++;
            if (xfer_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL sb_xfer_cnt: got %0d expected %0d", xfer_cnt, exp_cnt);
            end
            if (exp_valid && out_ready) begin
                automatic exp_t e = sb.pop_front();
                checks++;
                if (bus_out !== e.data || sel_err !== e.err) begin
                    failures++;
                    $display("FAIL sb_data: got %h/%b expected %h/%b", bus_out, sel_err, e.data, e.err);
                end
`ifdef READ_BUS_PARITY_EN
                checks++;
                if (bus_par !== e.par) begin
                    failures++;
                    $display("FAIL sb_parity: got %b expected %b", bus_par, e.par);
                end
`endif
                exp_cnt = exp_cnt + CNTW'(1);
            end
            if (in_valid && exp_ready) sb.push_back(model(bus_en));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        step();
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        // Leave a stalled transfer in flight, then reset over it.
        src[2]    = 32'hDEAD_BEEF;
        bus_en    = 3'd3;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (bus_out !== '0) begin
            failures++;
            $display("FAIL reset_bus_out: got %h expected 0", bus_out);
        end
        checks++;
        if (xfer_cnt !== '0 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt_err: got %0d/%b expected 0/0", xfer_cnt, sel_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_select();
        src[0]    = 32'h0000_0011;
        src[5]    = 32'hA5A5_A5A5;
        bus_en    = 3'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (bus_out !== 32'hA5A5_A5A5 || out_valid !== 1'b1 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL select_src5: got %h/%b/%b expected a5a5a5a5/1/0", bus_out, out_valid, sel_err);
        end
        bus_en = 3'd1;
        step();
        checks++;
        if (bus_out !== 32'h0000_0011) begin
            failures++;
            $display("FAIL select_src0: got %h expected 00000011", bus_out);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal_zero();
        for (int k = 0; k < N_SRC; k++) src[k] = 32'hC0DE_0000 | k;
        bus_en    = 3'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (bus_out !== '0 || sel_err !== 1'b1) begin
            failures++;
            $display("FAIL illegal_code: got %h/%b expected 0/1", bus_out, sel_err);
        end
        bus_en = 3'd0;
        step();
        checks++;
        if (bus_out !== '0 || sel_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_code: got %h/%b expected 0/0", bus_out, sel_err);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [CNTW-1:0] cnt_before;
        src[3]    = 32'h0000_1234;
        bus_en    = 3'd4;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            src[3] = 32'h5555_0000 + i;
            bus_en = SELW'(i + 1);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready);
            end
            step();
            checks++;
            if (bus_out !== 32'h0000_1234 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got %h/%b expected 00001234/1", i, bus_out, out_valid);
            end
        end
        cnt_before = exp_cnt;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if (xfer_cnt !== cnt_before + CNTW'(1) || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL release_cnt: got %0d/%b expected %0d/0", xfer_cnt, out_valid, cnt_before + CNTW'(1));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < N_SRC; k++) src[k] = 32'h1000_0000 * (k + 1) + k;
        out_ready = 1'b1;
        for (int round = 0; round < 2; round++) begin
            in_valid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                bus_en = SELW'(i);
                step();
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_bubble[%0d.%0d]: got %b expected 1", round, i, out_valid);
                end
            end
            in_valid = 1'b0;
            step();
            checks++;
            if (xfer_cnt !== CNTW'(8 * (round + 1))) begin
                failures++;
                $display("FAIL b2b_count[%0d]: got %0d expected %0d", round, xfer_cnt, CNTW'(8 * (round + 1)));
            end
        end
    endtask

`ifdef READ_BUS_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bus_en    = 3'd1;
        src[0]    = 32'h0000_0007;
        step();
        checks++;
        if (bus_par !== 1'b1) begin
            failures++;
            $display("FAIL parity_7: got %b expected 1", bus_par);
        end
        src[0] = 32'h0000_0003;
        step();
        checks++;
        if (bus_par !== 1'b0) begin
            failures++;
            $display("FAIL parity_3: got %b expected 0", bus_par);
        end
        in_valid = 1'b0;
        step();
    endtask
`endif

    initial begin
        for (int k = 0; k < N_SRC; k++) src[k] = '0;
        do_reset();
        test_reset();
        test_select();
        test_illegal_zero();
        test_backpressure();
        test_back_to_back();
`ifdef READ_BUS_PARITY_EN
        test_parity();
`endif
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
